// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - scan control and display drive bundle between a controller and seg_scan
interface seg_scan_if;
  logic       en;
  logic [3:0] digit_mask;
  logic [3:0] pos_idx;
  logic [3:0] an;
  logic       digit_strobe;
  logic       frame_done;

  modport master (
    output en, digit_mask,
    input  pos_idx, an, digit_strobe, frame_done
  );

  modport slave (
    input  en, digit_mask,
    output pos_idx, an, digit_strobe, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - 4-digit seven-segment scan sequencer with masked digits
// Optional all-off dead time between digits: define SEG_SCAN_DEADTIME_EN.
module seg_scan #(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned DEAD = 500
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  if (DIV < 2 || DIV > 65535 || DEAD < 1 || DEAD > 65535) begin : g_param_range_error
    $error("seg_scan: DIV or DEAD out of range");
  end

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

`ifdef SEG_SCAN_DEADTIME_EN
  localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_DEAD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  an_q, an_d;
  logic        strobe_q, strobe_d;
  logic        frame_q, frame_d;

  logic [1:0]  low_idx;
  logic [1:0]  nxt_idx;
  logic        advance;

  // First set mask bit at or cyclically after start; lowest offset wins.
  function automatic logic [1:0] scan_from(input logic [3:0] m, input logic [1:0] start);
    logic [1:0] r;
    r = start;
    for (int k = 3; k >= 0; k--) begin
      if (m[start + 2'(k)]) r = start + 2'(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    an_d     = 4'hF;
    strobe_d = 1'b0;
    frame_d  = 1'b0;
    advance  = 1'b0;
    low_idx  = scan_from(bus.digit_mask, 2'd0);
    nxt_idx  = scan_from(bus.digit_mask, idx_q + 2'd1);

    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|bus.digit_mask) begin
            state_d  = S_ON;
            idx_d    = low_idx;
            cnt_d    = '0;
            an_d     = decode(low_idx);
            strobe_d = 1'b1;
          end
        end
        S_ON: begin
          if (cnt_q == DIV_LAST) begin
`ifdef SEG_SCAN_DEADTIME_EN
            state_d = S_DEAD;
            cnt_d   = '0;
`else
            advance = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 16'd1;
            // A digit unmasked mid-display goes dark but keeps its time slot.
            if (bus.digit_mask[idx_q]) an_d = decode(idx_q);
          end
        end
`ifdef SEG_SCAN_DEADTIME_EN
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) advance = 1'b1;
          else cnt_d = cnt_q + 16'd1;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (advance) begin
        cnt_d = '0;
        if (|bus.digit_mask) begin
          state_d  = S_ON;
          idx_d    = nxt_idx;
          an_d     = decode(nxt_idx);
          strobe_d = 1'b1;
          frame_d  = (nxt_idx <= idx_q);
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      an_q     <= 4'hF;
      strobe_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.pos_idx      = {2'b00, idx_q};
  assign bus.an           = an_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.frame_done   = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan with DIV=4, DEAD=2
// Expectations follow SEG_SCAN_DEADTIME_EN the same way the design build does.
module tb_seg_scan;

  logic clk;
  logic rst_n;

  seg_scan_if bus ();

  seg_scan #(.DIV(4), .DEAD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] idx;
    logic       strobe;
    logic       frame;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dec(input logic [1:0] i);
    case (i)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Monitor: every negedge checks anode overlap and retires one scoreboard entry if present.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n_compared++;
      if ($countones(~bus.an) > 1) begin
        n_mismatched++;
        $display("FAIL overlap: an=%b has more than one low bit", bus.an);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_compared++;
        if ({bus.an, bus.pos_idx, bus.digit_strobe, bus.frame_done} !==
            {e.an, e.idx, e.strobe, e.frame}) begin
          n_mismatched++;
          $display("FAIL %s: got an=%b idx=%0d strobe=%b frame=%b, want an=%b idx=%0d strobe=%b frame=%b",
                   e.name, bus.an, bus.pos_idx, bus.digit_strobe, bus.frame_done,
                   e.an, e.idx, e.strobe, e.frame);
        end
      end
    end
  end

  // Push the expectation for the state after the coming edge, then move to the next cycle.
  task automatic cyc(input logic [3:0] a, input logic [1:0] i, input logic s, input logic f,
                     input string nm);
    exp_t e;
    e.an = a; e.idx = {2'b00, i}; e.strobe = s; e.frame = f; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic digit(input logic [1:0] i, input logic f, input string nm);
    cyc(dec(i), i, 1'b1, f, {nm, "_strobe"});
    for (int k = 1; k < 4; k++) cyc(dec(i), i, 1'b0, 1'b0, nm);
`ifdef SEG_SCAN_DEADTIME_EN
    for (int k = 0; k < 2; k++) cyc(4'hF, i, 1'b0, 1'b0, {nm, "_dead"});
`endif
  endtask

  task automatic direct(input logic [3:0] got, input logic [3:0] want, input string nm);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b1;
    bus.digit_mask = 4'b1111;
    @(negedge clk);
    #1;

    cyc(4'hF, 2'd0, 1'b0, 1'b0, "rst_hold");
    cyc(4'hF, 2'd0, 1'b0, 1'b0, "rst_hold");
    rst_n = 1'b1;

    digit(2'd0, 1'b0, "first_d0");
    digit(2'd1, 1'b0, "full_d1");
    digit(2'd2, 1'b0, "full_d2");
    digit(2'd3, 1'b0, "full_d3");
    digit(2'd0, 1'b1, "wrap_d0");
    digit(2'd1, 1'b0, "full_d1");
    digit(2'd2, 1'b0, "full_d2");
    digit(2'd3, 1'b0, "full_d3");
    digit(2'd0, 1'b1, "wrap_d0");

    bus.digit_mask = 4'b0101;
    digit(2'd2, 1'b0, "sparse_d2");
    digit(2'd0, 1'b1, "sparse_d0");
    digit(2'd2, 1'b0, "sparse_d2");
    digit(2'd0, 1'b1, "sparse_d0");

    cyc(4'b1011, 2'd2, 1'b1, 1'b0, "drop_d2_strobe");
    cyc(4'b1011, 2'd2, 1'b0, 1'b0, "drop_d2_on2");
    bus.en = 1'b0;
    cyc(4'hF, 2'd2, 1'b0, 1'b0, "en_drop");
    cyc(4'hF, 2'd2, 1'b0, 1'b0, "idle_hold");
    bus.digit_mask = 4'b0110;
    bus.en         = 1'b1;
    cyc(4'b1101, 2'd1, 1'b1, 1'b0, "resume_d1");
    cyc(4'b1101, 2'd1, 1'b0, 1'b0, "resume_d1");
    cyc(4'b1101, 2'd1, 1'b0, 1'b0, "resume_d1");
`ifdef SEG_SCAN_DEADTIME_EN
    cyc(4'b1101, 2'd1, 1'b0, 1'b0, "resume_d1");
    cyc(4'hF,    2'd1, 1'b0, 1'b0, "resume_dead");
`endif

    #2;
    rst_n = 1'b0;
    #1;
    direct(bus.an, 4'hF, "async_rst_an");
    direct(bus.pos_idx, 4'd0, "async_rst_idx");
    direct({3'b000, bus.digit_strobe}, 4'd0, "async_rst_strobe");
    direct({3'b000, bus.frame_done}, 4'd0, "async_rst_frame");
    @(negedge clk);
    #1;
    cyc(4'hF, 2'd0, 1'b0, 1'b0, "in_reset");
    rst_n = 1'b1;
    cyc(4'b1101, 2'd1, 1'b1, 1'b0, "post_rst_d1");

    bus.digit_mask = 4'b0100;
    for (int k = 1; k < 4; k++) cyc(4'hF, 2'd1, 1'b0, 1'b0, "mask_clr_dark");
`ifdef SEG_SCAN_DEADTIME_EN
    for (int k = 0; k < 2; k++) cyc(4'hF, 2'd1, 1'b0, 1'b0, "mask_clr_dead");
`endif
    digit(2'd2, 1'b0, "after_clr_d2");
    digit(2'd2, 1'b1, "single_d2");

    bus.digit_mask = 4'b0000;
    cyc(4'hF, 2'd2, 1'b0, 1'b0, "mask0_idle");
    cyc(4'hF, 2'd2, 1'b0, 1'b0, "mask0_idle");
    bus.digit_mask = 4'b1000;
    cyc(4'b0111, 2'd3, 1'b1, 1'b0, "mask8_start");
    cyc(4'b0111, 2'd3, 1'b0, 1'b0, "mask8_on");

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Digit-scan sequencer for the 4-digit multiplexed seven-segment display. It generates the digit position index and the matching active-low anode enables on a fixed time base, skips masked digits, and optionally inserts an all-off dead time between digits to suppress ghosting. Its `pos_idx` output is the encoded digit index consumed by the position decoder and the segment-data mux. Its `an` output is the equivalent decoded anode drive.

## Interface
- `DIV`, 50000: clock cycles each digit is driven (1 kHz per digit at 50 MHz); legal range 2..65535.
- `DEAD`, 500: all-off cycles between digits; legal range 1..65535; used only when the dead-time macro is defined.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable.
- `digit_mask`  in  4  bit i=1: digit i takes part in the scan.
- `pos_idx`  out  4  current digit index, 0..3; bits [3:2] are always 0.
- `an`  out  4  active-low anodes; idx0→1110, idx1→1101, idx2→1011, idx3→0111, off→1111.
- `digit_strobe`  out  1  one-cycle pulse on the first cycle a digit is driven.
- `frame_done`  out  1  one-cycle pulse when the scan wraps to the lowest enabled digit.

## Operation
- All outputs are registered and update on the same `clk` edge as the state.
- Reset values: state IDLE, `pos_idx`=0, `an`=1111, `digit_strobe`=0, `frame_done`=0, and the 16-bit cycle counter=0.
- **IDLE**
  - `an`=1111.
  - If `en`=1 and `digit_mask`≠0, go to ON with the lowest enabled index, the counter at 0, and `digit_strobe`=1.
- **ON**
  - `an` = decode(`pos_idx`).
  - The counter increments each cycle. When it reaches DIV−1, go to DEAD with `an`=1111, or go to the next digit if the macro is absent.
- **DEAD**
  - `an`=1111.
  - The counter counts DEAD cycles. After that, go to ON with the next digit and pulse `digit_strobe`.
- **Next digit**
  - The next digit is the next index above the current one, taken cyclically, whose `digit_mask` bit is set.
  - If the search wraps, meaning next ≤ current, pulse `frame_done` together with `digit_strobe`.
  - With a single enabled digit, that digit repeats, and both pulses fire every period.
- **Mask changes**
  - A change in `digit_mask` is sampled only at digit selection.
  - Exception: if the current digit's mask bit clears during ON, `an`=1111 from the next edge. The state and counter continue.
  - If `digit_mask`=0 at digit selection, go to IDLE.
- **Enable drop**
  - `en`=0 in any state sends the block to IDLE at the next edge: `an`=1111, the counter clears, and `pos_idx` holds.
  - When `en` is re-enabled, scanning restarts at the lowest enabled digit.
- **Reset mid-operation:** asserting `rst_n` forces the reset values immediately, without waiting for a clock edge.

## Timing
- From `en` sampled high in IDLE to `an` low: 1 edge.
- Each digit's `an` is low for exactly DIV cycles.
- Gap between digits: DEAD cycles at `an`=1111 with the macro, 0 without.
- Digit period: DIV+DEAD (or DIV). Frame period: N×(DIV+DEAD), where N is the number of enabled digits.
- Anode overlap is never allowed: at most one `an` bit is 0 in any cycle.

## Configuration
- `SEG_SCAN_DEADTIME_EN` defined:
  - DEAD state is present.
  - The all-off gap of DEAD cycles is inserted between every pair of consecutive digits, including at the wrap.
- Macro absent:
  - DEAD state and its logic are removed, and the `DEAD` parameter is ignored.
  - ON moves directly to the next ON, and `an` switches from one digit to the next in a single edge.

## Test plan
Bench parameters: DIV=4, DEAD=2.

1. Reset: hold `rst_n`=0 with `en`=1 → `an`=1111, `pos_idx`=0, no pulses. Release reset → the first `an`=1110 appears 1 edge later.
2. Macro on, `mask`=1111 → `an` shows 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, 1111×2, then repeats. `frame_done` fires every 24 cycles, aligned with the idx0 `digit_strobe`.
3. Sparse mask, `mask`=0101 → `pos_idx` sequence 0,2,0,2. `an` alternates 1110 and 1011. `frame_done` fires every 12 cycles.
4. Enable drop: `en`=0 in the 2nd ON cycle of idx2 → `an`=1111 at the next edge, IDLE. `en`=1 with `mask`=0110 → the scan resumes at idx1 (`an`=1101).
5. Async reset: assert `rst_n` low mid-DEAD between edges → all outputs take their reset values immediately.
6. Macro off, `mask`=1111 → `an` shows 1110×4, then 1101 on the very next cycle with no 1111 gap. Frame period is 16 cycles, and exactly one anode is low in every cycle.
